mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory (memory4c) between the I-cache and D-cache miss FSMs.
//  - Grants one owner per miss transaction and forwards only that owner's enable, write, address and data.
//  - Steers returning data_valid beats to the cache that issued the reads.
//  - Drains in-flight reads before handing the memory to the other cache.
//  - Sits between both Cache instances and Main_Mem in cpu.
// PARAMETERS
//  ADDR_W   16  address/data width
//  MAX_OUT  4   max outstanding reads (memory read latency); counter width = $clog2(MAX_OUT+1)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-high reset
//  i_busy     in   1       I-cache miss FSM busy
//  i_req      in   1       I-cache read request
//  i_addr     in   ADDR_W  I-cache miss address
//  d_busy     in   1       D-cache miss FSM busy
//  d_req      in   1       D-cache read request
//  d_wr       in   1       D-cache write (write-through, single beat)
//  d_addr     in   ADDR_W  D-cache address
//  d_wdata    in   ADDR_W  D-cache write data
//  mem_valid  in   1       memory data_valid
//  mem_en     out  1       memory enable
//  mem_wr     out  1       memory write
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  ADDR_W  memory write data
//  gnt_i      out  1       I-cache owns memory (registered)
//  gnt_d      out  1       D-cache owns memory (registered)
//  i_valid    out  1       mem_valid routed to I-cache
//  d_valid    out  1       mem_valid routed to D-cache
// BEHAVIOUR
//  - Reset: state IDLE, outstanding cnt 0, owner D, gnt_i/gnt_d 0; all comb outputs 0 while no grant.
//  - FSM states: IDLE, GNT_I, GNT_D, DRAIN.
//    - IDLE: d_busy|d_wr -> GNT_D; else i_busy -> GNT_I. Both pending -> D wins.
//    - GNT_x -> DRAIN when x_busy=0 and no x request this cycle, if cnt!=0 or cnt_next!=0;
//      with cnt=0 and cnt_next=0 -> IDLE directly.
//    - DRAIN -> IDLE when cnt_next==0.
//  - Grant latency: gnt_x rises 1 cycle after x_busy; requesters hold req/addr stable until gnt_x=1.
//  - Forwarding (combinational):
//    - GNT_I: mem_en=i_req&~sat, mem_wr=0, mem_addr=i_addr, mem_wdata=0.
//    - GNT_D: mem_en=(d_req&~sat)|d_wr, mem_wr=d_wr, mem_addr=d_addr, mem_wdata=d_wdata.
//    - IDLE/DRAIN: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
//  - Outstanding counter:
//    - +1 on mem_en&~mem_wr; -1 on mem_valid&cnt!=0; both same cycle -> unchanged.
//    - sat = (cnt==MAX_OUT): blocks new reads; writes are uncounted and never blocked.
//  - Valid routing: owner register updates on entry to GNT_x and holds through DRAIN.
//    - i_valid = mem_valid&(cnt!=0)&owner==I; d_valid likewise for D.
//  - mem_valid with cnt==0 is dropped: no valid output, cnt stays 0.
//  - Reset mid-transaction: immediate return to reset values; late beats are dropped (cnt==0).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - Tie in IDLE goes to the side that was not the last owner.
//    - Last owner resets to D, so the first tie after reset goes to I.
//  ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority; last-owner state is not built.
// TESTING
//  1. I miss alone: i_busy=1 @c0, i_req held -> gnt_i=1 @c1, 4 reads issued @c1..c4,
//     i_valid on 4 returns, IDLE 1 cycle after last valid with i_busy=0.
//  2. Simultaneous i_busy/d_busy @c0 -> gnt_d=1 @c1, gnt_i=0 until D drained;
//     then gnt_i=1 (round robin: gnt_i first).
//  3. D busy drops with 3 reads in flight -> DRAIN, 3 d_valid pulses, mem_en=0 throughout,
//     then I granted; no i_valid during drain.
//  4. d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_en=1, mem_wr=1, mem_addr=0x0040,
//     mem_wdata=0xBEEF in the granted cycle; cnt stays 0.
//  5. Hold i_req with no returns -> after 4 issues mem_en=0 (sat); one mem_valid -> exactly one more issue.
//  6. rst pulse with cnt=2 mid-GNT_I -> gnt_i=0, mem_en=0 at once;
//     subsequent mem_valid beats produce no i_valid/d_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single multi-cycle main memory between the
// I-cache and D-cache miss FSMs. One cache owns the memory per miss
// transaction. Read beats that are still in flight are drained before the
// other cache is granted, and each returning beat is steered to the cache
// that issued the reads.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve an I/D tie in IDLE
// in favour of the side that was not the last owner. Without it, D always
// wins a tie.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_busy,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  input  logic              mem_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              i_valid,
  output logic              d_valid
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;

  state_t        state, state_next;
  // The owner register doubles as the last-owner memory used for round-robin
  // ties, because it is loaded only when a grant is taken and holds otherwise.
  owner_t        owner, owner_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          cnt_nz;
  logic          sat;
  logic          rd_issue;
  logic          rd_retire;
  logic          d_pend;
  logic          i_pend;

  assign cnt_nz    = (cnt != '0);
  assign sat       = (cnt == CW'(MAX_OUT));
  assign rd_issue  = mem_en & ~mem_wr;
  // A beat arriving with nothing outstanding is stale (for example after a
  // reset) and is dropped here.
  assign rd_retire = mem_valid & cnt_nz;
  assign i_valid   = rd_retire & (owner == OWN_I);
  assign d_valid   = rd_retire & (owner == OWN_D);
  assign d_pend    = d_busy | d_wr;
  assign i_pend    = i_busy;

  // Forward only the granted cache's request; the memory sees nothing otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      GNT_I: begin
        mem_en   = i_req & ~sat;
        mem_addr = i_addr;
      end
      GNT_D: begin
        mem_en    = (d_req & ~sat) | d_wr;
        mem_wr    = d_wr;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Outstanding-read count: a read issue and a beat retire in the same cycle cancel.
  always_comb begin
    cnt_next = cnt;
    if (rd_issue && !rd_retire) begin
      cnt_next = cnt + CW'(1);
    end else if (!rd_issue && rd_retire) begin
      cnt_next = cnt - CW'(1);
    end
  end

  // Next-state and owner selection for the grant FSM.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_pend && i_pend) begin
          if (owner == OWN_D) begin
            state_next = GNT_I;
            owner_next = OWN_I;
          end else begin
            state_next = GNT_D;
            owner_next = OWN_D;
          end
        end else if (d_pend) begin
          state_next = GNT_D;
          owner_next = OWN_D;
        end else if (i_pend) begin
          state_next = GNT_I;
          owner_next = OWN_I;
        end
`else
        if (d_pend) begin
          state_next = GNT_D;
          owner_next = OWN_D;
        end else if (i_pend) begin
          state_next = GNT_I;
          owner_next = OWN_I;
        end
`endif
      end
      GNT_I: begin
        if (!i_busy && !i_req) begin
          state_next = (cnt_nz || (cnt_next != '0)) ? DRAIN : IDLE;
        end
      end
      GNT_D: begin
        if (!d_busy && !d_req && !d_wr) begin
          state_next = (cnt_nz || (cnt_next != '0)) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (cnt_next == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, owner, counter and registered grant flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_D;
      cnt   <= '0;
      gnt_i <= 1'b0;
      gnt_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that were current before this edge, whatever the statement order.
      state <= state_next;
      owner <= owner_next;
      cnt   <= cnt_next;
      gnt_i <= (state_next == GNT_I);
      gnt_d <= (state_next == GNT_D);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences, and randomized traffic compared
// against a behavioural model kept in the bench.
module tb_mem_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_busy, i_req, d_busy, d_req, d_wr, mem_valid;
  logic [AW-1:0] i_addr, d_addr, d_wdata;
  logic          mem_en, mem_wr, gnt_i, gnt_d, i_valid, d_valid;
  logic [AW-1:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_busy(i_busy), .i_req(i_req), .i_addr(i_addr),
    .d_busy(d_busy), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_valid(mem_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .gnt_i(gnt_i), .gnt_d(gnt_d), .i_valid(i_valid), .d_valid(d_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // holder: 0 nobody, 1 I-cache, 2 D-cache
  int          m_hold;
  bit          m_drain;
  int          m_cnt;
  bit          m_own_i;
  logic        e_en, e_wr, e_gi, e_gd, e_iv, e_dv;
  logic [AW-1:0] e_addr, e_wdata;

  task automatic model_reset();
    m_hold = 0; m_drain = 0; m_cnt = 0; m_own_i = 0;
  endtask

  task automatic model_expect();
    bit full;
    full    = (m_cnt == 4);
    e_en    = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    if (m_hold == 1) begin
      e_en   = i_req && !full;
      e_addr = i_addr;
    end else if (m_hold == 2) begin
      e_en    = (d_req && !full) || d_wr;
      e_wr    = d_wr;
      e_addr  = d_addr;
      e_wdata = d_wdata;
    end
    e_gi = (m_hold == 1);
    e_gd = (m_hold == 2);
    e_iv = mem_valid && (m_cnt > 0) && m_own_i;
    e_dv = mem_valid && (m_cnt > 0) && !m_own_i;
  endtask

  task automatic model_advance();
    int nc;
    bit dp, ip, take_i;
    nc = m_cnt + ((e_en && !e_wr) ? 1 : 0) - ((mem_valid && m_cnt > 0) ? 1 : 0);
    if (m_hold == 0 && !m_drain) begin
      dp = d_busy || d_wr;
      ip = i_busy;
`ifdef ARB_ROUND_ROBIN_EN
      take_i = (dp && ip) ? !m_own_i : ip;
`else
      take_i = ip && !dp;
`endif
      if (take_i) begin
        m_hold = 1; m_own_i = 1;
      end else if (dp) begin
        m_hold = 2; m_own_i = 0;
      end
    end else if (m_hold == 1) begin
      if (!i_busy && !i_req) begin
        m_hold = 0; m_drain = (m_cnt > 0) || (nc > 0);
      end
    end else if (m_hold == 2) begin
      if (!d_busy && !d_req && !d_wr) begin
        m_hold = 0; m_drain = (m_cnt > 0) || (nc > 0);
      end
    end else if (m_drain && nc == 0) begin
      m_drain = 0;
    end
    m_cnt = nc;
  endtask

  task automatic compare_model(input string tag);
    model_expect();
    check({tag, ".mem_en"},    32'(mem_en),    32'(e_en));
    check({tag, ".mem_wr"},    32'(mem_wr),    32'(e_wr));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
    check({tag, ".gnt_i"},     32'(gnt_i),     32'(e_gi));
    check({tag, ".gnt_d"},     32'(gnt_d),     32'(e_gd));
    check({tag, ".i_valid"},   32'(i_valid),   32'(e_iv));
    check({tag, ".d_valid"},   32'(d_valid),   32'(e_dv));
  endtask

  // Called at posedge+1 with inputs already driven; ends at next posedge+1.
  task automatic step(input string tag);
    #1;
    compare_model(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    i_busy = 0; i_req = 0; i_addr = '0;
    d_busy = 0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    mem_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          ib, ir;
    logic [AW-1:0] ia;
    logic          db, dr, dw;
    logic [AW-1:0] da, dd;
    logic          mv;
    logic          en, wr;
    logic [AW-1:0] addr, wdata;
    logic          gi, gd, iv, dv;
  } vec_t;

  function automatic vec_t mk(
      logic ib, logic ir, logic [AW-1:0] ia, logic db, logic dr, logic dw,
      logic [AW-1:0] da, logic [AW-1:0] dd, logic mv,
      logic en, logic wr, logic [AW-1:0] addr, logic [AW-1:0] wdata,
      logic gi, logic gd, logic iv, logic dv);
    vec_t v;
    v.ib = ib; v.ir = ir; v.ia = ia; v.db = db; v.dr = dr; v.dw = dw;
    v.da = da; v.dd = dd; v.mv = mv;
    v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.gi = gi; v.gd = gd; v.iv = iv; v.dv = dv;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int budget;
    zero_inputs();

    // Write-through beat, then an I miss that saturates, refills and drains.
    vecs[0]  = mk(0,0,16'h0000, 0,0,1,16'h0040,16'hBEEF, 0,  0,0,16'h0000,16'h0000, 0,0,0,0);
    vecs[1]  = mk(0,0,16'h0000, 0,0,1,16'h0040,16'hBEEF, 0,  1,1,16'h0040,16'hBEEF, 0,1,0,0);
    vecs[2]  = mk(0,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000, 0,1,0,0);
    vecs[3]  = mk(1,1,16'h0100, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0000,16'h0000, 0,0,0,0);
    vecs[4]  = mk(1,1,16'h0100, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0100,16'h0000, 1,0,0,0);
    vecs[5]  = mk(1,1,16'h0101, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0101,16'h0000, 1,0,0,0);
    vecs[6]  = mk(1,1,16'h0102, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0102,16'h0000, 1,0,0,0);
    vecs[7]  = mk(1,1,16'h0103, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0103,16'h0000, 1,0,0,0);
    vecs[8]  = mk(1,1,16'h0104, 0,0,0,16'h0000,16'h0000, 0,  0,0,16'h0104,16'h0000, 1,0,0,0);
    vecs[9]  = mk(1,1,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0104,16'h0000, 1,0,1,0);
    vecs[10] = mk(1,1,16'h0104, 0,0,0,16'h0000,16'h0000, 0,  1,0,16'h0104,16'h0000, 1,0,0,0);
    vecs[11] = mk(0,0,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0104,16'h0000, 1,0,1,0);
    vecs[12] = mk(0,0,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000, 0,0,1,0);
    vecs[13] = mk(0,0,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000, 0,0,1,0);
    vecs[14] = mk(0,0,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000, 0,0,1,0);
    vecs[15] = mk(0,0,16'h0104, 0,0,0,16'h0000,16'h0000, 1,  0,0,16'h0000,16'h0000, 0,0,0,0);

    // Reset state.
    do_reset();
    #1;
    check("reset.gnt_i",  32'(gnt_i),  32'd0);
    check("reset.gnt_d",  32'(gnt_d),  32'd0);
    check("reset.mem_en", 32'(mem_en), 32'd0);

    for (int k = 0; k < 16; k++) begin
      i_busy = vecs[k].ib; i_req = vecs[k].ir; i_addr = vecs[k].ia;
      d_busy = vecs[k].db; d_req = vecs[k].dr; d_wr = vecs[k].dw;
      d_addr = vecs[k].da; d_wdata = vecs[k].dd; mem_valid = vecs[k].mv;
      #1;
      check($sformatf("vec%0d.mem_en", k),    32'(mem_en),    32'(vecs[k].en));
      check($sformatf("vec%0d.mem_wr", k),    32'(mem_wr),    32'(vecs[k].wr));
      check($sformatf("vec%0d.mem_addr", k),  32'(mem_addr),  32'(vecs[k].addr));
      check($sformatf("vec%0d.mem_wdata", k), 32'(mem_wdata), 32'(vecs[k].wdata));
      check($sformatf("vec%0d.gnt_i", k),     32'(gnt_i),     32'(vecs[k].gi));
      check($sformatf("vec%0d.gnt_d", k),     32'(gnt_d),     32'(vecs[k].gd));
      check($sformatf("vec%0d.i_valid", k),   32'(i_valid),   32'(vecs[k].iv));
      check($sformatf("vec%0d.d_valid", k),   32'(d_valid),   32'(vecs[k].dv));
      @(posedge clk);
      #1;
    end

    // Simultaneous I/D misses, D drains three reads, then I is served.
    do_reset();
    i_busy = 1; i_req = 1; i_addr = 16'h0200;
    d_busy = 1; d_req = 1; d_addr = 16'h0300;
    step("tie.c0");
`ifndef ARB_ROUND_ROBIN_EN
    check("tie.gnt_d_first", 32'(gnt_d), 32'd1);
    check("tie.gnt_i_held",  32'(gnt_i), 32'd0);
`else
    check("tie.gnt_i_first", 32'(gnt_i), 32'd1);
`endif
    step("tie.c1");
    step("tie.c2");
    step("tie.c3");
    d_busy = 0; d_req = 0;
    step("tie.release");
    mem_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain.mem_en", 32'(mem_en),  32'd0);
      check("drain.i_valid", 32'(i_valid), 32'd0);
      step("drain.beat");
    end
    mem_valid = 0;
    budget = 0;
    while (!gnt_i && budget < 20) begin
      step("tie.wait_i");
      budget++;
    end
    check("tie.i_granted", 32'(gnt_i), 32'd1);
    step("tie.i_issue");
    i_busy = 0; i_req = 0;
    step("tie.i_release");
    mem_valid = 1;
    repeat (6) step("tie.i_drain");
    mem_valid = 0;

    // Reset while I owns the memory with two reads in flight.
    do_reset();
    i_busy = 1; i_req = 1; i_addr = 16'h0055;
    step("rst.c0");
    step("rst.c1");
    step("rst.c2");
    #1;
    check("rst.pre_gnt_i", 32'(gnt_i), 32'd1);
    rst = 1;
    #1;
    check("rst.gnt_i",  32'(gnt_i),  32'd0);
    check("rst.mem_en", 32'(mem_en), 32'd0);
    model_reset();
    i_busy = 0; i_req = 0;
    @(posedge clk);
    #1;
    rst = 0;
    mem_valid = 1;
    step("rst.late0");
    check("rst.late_i_valid", 32'(i_valid), 32'd0);
    step("rst.late1");
    check("rst.late_d_valid", 32'(d_valid), 32'd0);
    mem_valid = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) i_busy = ~i_busy;
      if ($urandom_range(7) == 0) d_busy = ~d_busy;
      i_req     = i_busy & ($urandom_range(2) != 0);
      d_req     = d_busy & ($urandom_range(2) != 0);
      d_wr      = ($urandom_range(11) == 0);
      i_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      d_wdata   = AW'($urandom);
      mem_valid = ($urandom_range(2) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
